// File: rtl/press_classifier_pkg.sv
// rtl/press_classifier_pkg.sv - state codes and 100 MHz default timing for press_classifier
package press_classifier_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PRESSED   = 3'd1;
  localparam state_t ST_LONG_HELD = 3'd2;
  localparam state_t ST_WAIT      = 3'd3;
  localparam state_t ST_SECOND    = 3'd4;
  localparam state_t ST_LOCKOUT   = 3'd5;

  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_DCLICK_CYCLES = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_CNT_W         = 26;

  function automatic logic is_held(input state_t s);
    return (s == ST_PRESSED) || (s == ST_LONG_HELD) || (s == ST_SECOND);
  endfunction

endpackage

// File: rtl/press_classifier_event_timer.sv
// rtl/press_classifier_event_timer.sv - event_timer: clearable cycle counter with terminal-count compare
module event_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // limit is already "count minus one", so terminal lands on the last cycle of the window
  assign terminal = run && (cnt_q == limit);

endmodule

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - short/long/double-click classifier; auto-repeat under PRESS_CLASSIFIER_AUTOREPEAT_EN
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_state,
  input  logic btn_press,
  input  logic btn_release,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_strobe,
  output logic held
);

  state_t state_q, state_d;
  logic   startup_q, startup_d;
  logic   short_q, short_d;
  logic   long_q, long_d;
  logic   dclick_q, dclick_d;
  logic   rpt_q, rpt_d;

  logic             run;
  logic             clear;
  logic             terminal;
  logic [CNT_W-1:0] limit;
  logic             press_only;
  logic             release_only;

  // simultaneous press and release pulses cancel each other
  assign press_only   = btn_press && !btn_release;
  assign release_only = btn_release && !btn_press;

  always_comb begin
    case (state_q)
      ST_PRESSED: limit = CNT_W'(LONG_CYCLES - 1);
      ST_WAIT:    limit = CNT_W'(DCLICK_CYCLES - 1);
      default:    limit = CNT_W'(REPEAT_CYCLES - 1);
    endcase
  end

`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
  assign run = state_q inside {ST_PRESSED, ST_WAIT, ST_LONG_HELD};
`else
  assign run = state_q inside {ST_PRESSED, ST_WAIT};
`endif

  always_comb begin
    state_d   = state_q;
    startup_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    dclick_d  = 1'b0;
    rpt_d     = 1'b0;
    // first cycle out of reset: a button already down must not be classified
    if (startup_q) begin
      state_d = btn_state ? ST_LOCKOUT : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_only) state_d = ST_PRESSED;
        end
        ST_PRESSED: begin
          if (release_only) begin
            state_d = ST_WAIT;
          end else if (terminal) begin
            state_d = ST_LONG_HELD;
            long_d  = 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (release_only) begin
            state_d = ST_IDLE;
          end
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
          else if (terminal) begin
            rpt_d = 1'b1;
          end
`endif
        end
        ST_WAIT: begin
          if (press_only) begin
            state_d = ST_SECOND;
          end else if (terminal) begin
            state_d = ST_IDLE;
            short_d = 1'b1;
          end
        end
        ST_SECOND: begin
          if (release_only) begin
            state_d  = ST_IDLE;
            dclick_d = 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (release_only || !btn_state) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // a repeat restarts the period just like a state entry
  assign clear = (state_d != state_q) || rpt_d;

  event_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .run     (run),
    .limit   (limit),
    .terminal(terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      startup_q <= 1'b1;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      dclick_q  <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      startup_q <= startup_d;
      short_q   <= short_d;
      long_q    <= long_d;
      dclick_q  <= dclick_d;
      rpt_q     <= rpt_d;
    end
  end

  assign short_press   = short_q;
  assign long_press    = long_q;
  assign double_click  = dclick_q;
  assign repeat_strobe = rpt_q;
  assign held          = is_held(state_q);

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - randomized and directed self-checking bench for press_classifier
module tb_press_classifier;

  localparam int L = 8;
  localparam int D = 4;
  localparam int R = 3;
`ifdef PRESS_CLASSIFIER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam int M_IDLE = 0, M_DOWN = 1, M_LONG = 2, M_GAP = 3, M_SECOND = 4, M_LOCK = 5;

  logic clk = 1'b0;
  logic rst, btn_state, btn_press, btn_release;
  logic short_press, long_press, double_click, repeat_strobe, held;

  always #5 clk = ~clk;

  press_classifier #(
    .LONG_CYCLES(L), .DCLICK_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_state(btn_state), .btn_press(btn_press),
    .btn_release(btn_release), .short_press(short_press), .long_press(long_press),
    .double_click(double_click), .repeat_strobe(repeat_strobe), .held(held)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;

  // behavioural model: mode plus timestamp of entry, durations by subtraction
  int m_mode = M_IDLE;
  int m_t = 0;
  bit m_start = 1'b1;
  bit e_short = 0, e_long = 0, e_dc = 0, e_rep = 0, e_held = 0;

  int short_n = 0, long_n = 0, dc_n = 0, rep_n = 0, held_n = 0;
  int short_last = 0, long_last = 0, dc_last = 0, rep_last = 0, held_last = 0;
  int d_short, d_long, d_dc, d_rep, d_held;
  int at_short, at_long, at_dc, at_rep, at_held;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit p, r;
    cyc++;
    e_short = 0; e_long = 0; e_dc = 0; e_rep = 0;
    p = btn_press && !btn_release;
    r = btn_release && !btn_press;
    if (rst) begin
      m_mode = M_IDLE;
      m_start = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0;
      m_mode = btn_state ? M_LOCK : M_IDLE;
      m_t = cyc;
    end else begin
      case (m_mode)
        M_IDLE: if (p) begin m_mode = M_DOWN; m_t = cyc; end
        M_DOWN: begin
          if (r) begin m_mode = M_GAP; m_t = cyc; end
          else if (cyc - m_t == L) begin m_mode = M_LONG; m_t = cyc; e_long = 1; end
        end
        M_LONG: begin
          if (r) m_mode = M_IDLE;
          else if (AR && ((cyc - m_t) % R == 0)) e_rep = 1;
        end
        M_GAP: begin
          if (p) m_mode = M_SECOND;
          else if (cyc - m_t == D) begin m_mode = M_IDLE; e_short = 1; end
        end
        M_SECOND: if (r) begin m_mode = M_IDLE; e_dc = 1; end
        default: if (r || !btn_state) m_mode = M_IDLE;
      endcase
    end
    e_held = (m_mode == M_DOWN) || (m_mode == M_LONG) || (m_mode == M_SECOND);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check($sformatf("outputs@%0d", cyc),
          int'({short_press, long_press, double_click, repeat_strobe, held}),
          int'({e_short, e_long, e_dc, e_rep, e_held}));
    if (short_press)   begin short_n++; short_last = cyc; end
    if (long_press)    begin long_n++;  long_last  = cyc; end
    if (double_click)  begin dc_n++;    dc_last    = cyc; end
    if (repeat_strobe) begin rep_n++;   rep_last   = cyc; end
    if (held)          begin held_n++;  held_last  = cyc; end
  endtask

  // directed scenario: edges relative to the first edge after reset release (edge 1)
  task automatic scen(input bit start_hi, input int r0, input int p1, input int r1,
                      input int p2, input int r2, input int both_at, input int n);
    int s0, l0, c0, q0, h0;
    rst = 1'b1; btn_state = start_hi; btn_press = 1'b0; btn_release = 1'b0;
    tick(); tick();
    rst = 1'b0;
    base = cyc;
    s0 = short_n; l0 = long_n; c0 = dc_n; q0 = rep_n; h0 = held_n;
    for (int e = 1; e <= n; e++) begin
      btn_state = (start_hi && e < r0) ||
                  (p1 != 0 && e >= p1 && e < r1) ||
                  (p2 != 0 && e >= p2 && e < r2);
      btn_press   = (e == p1) || (e == p2) || (e == both_at);
      btn_release = (e == r0) || (e == r1) || (e == r2) || (e == both_at);
      tick();
    end
    btn_state = 1'b0; btn_press = 1'b0; btn_release = 1'b0;
    d_short = short_n - s0; at_short = (d_short > 0) ? short_last - base : -1;
    d_long  = long_n - l0;  at_long  = (d_long > 0)  ? long_last - base  : -1;
    d_dc    = dc_n - c0;    at_dc    = (d_dc > 0)    ? dc_last - base    : -1;
    d_rep   = rep_n - q0;   at_rep   = (d_rep > 0)   ? rep_last - base   : -1;
    d_held  = held_n - h0;  at_held  = (d_held > 0)  ? held_last - base  : -1;
  endtask

  initial begin
    bit lvl;
    int cd, rr;
    rst = 1'b1; btn_state = 1'b0; btn_press = 1'b0; btn_release = 1'b0;
    tick(); tick(); tick();
    check("reset_outputs", int'({short_press, long_press, double_click, repeat_strobe, held}), 0);

    scen(0, 0, 10, 13, 0, 0, 0, 30);
    check("s1_short_count", d_short, 1);
    check("s1_short_edge", at_short, 17);
    check("s1_long_count", d_long, 0);
    check("s1_held_cycles", d_held, 3);
    check("s1_held_last", at_held, 12);

    scen(0, 0, 10, 30, 0, 0, 0, 40);
    check("s2_long_count", d_long, 1);
    check("s2_long_edge", at_long, 18);
    check("s2_repeat_count", d_rep, AR ? 3 : 0);
    check("s2_repeat_last", at_rep, AR ? 27 : -1);
    check("s2_short_count", d_short, 0);

    scen(0, 0, 10, 12, 14, 15, 0, 30);
    check("s3_dclick_count", d_dc, 1);
    check("s3_dclick_edge", at_dc, 15);
    check("s3_short_count", d_short, 0);
    check("s3_long_count", d_long, 0);

    scen(0, 0, 10, 18, 0, 0, 0, 30);
    check("s4_long_count", d_long, 0);
    check("s4_short_count", d_short, 1);
    check("s4_short_edge", at_short, 22);

    scen(1, 20, 30, 31, 0, 0, 0, 45);
    check("s5_short_count", d_short, 1);
    check("s5_short_edge", at_short, 35);
    check("s5_long_count", d_long, 0);
    check("s5_dclick_count", d_dc, 0);
    check("s5_held_cycles", d_held, 1);

    scen(0, 0, 0, 0, 0, 0, 10, 30);
    check("s6_any_activity", d_short + d_long + d_dc + d_rep + d_held, 0);

    rst = 1'b1; tick(); rst = 1'b0;
    lvl = 1'b0; cd = 3;
    for (int i = 0; i < 3000; i++) begin
      btn_press = 1'b0; btn_release = 1'b0;
      if (cd == 0) begin
        lvl = ~lvl;
        if (lvl) btn_press = 1'b1; else btn_release = 1'b1;
        cd = $urandom_range(1, 12);
      end else begin
        cd--;
      end
      btn_state = lvl;
      rr = $urandom_range(0, 99);
      if (rr < 2) begin btn_press = 1'b1; btn_release = 1'b1; end
      else if (rr < 4) btn_press = 1'b1;
      else if (rr < 6) btn_release = 1'b1;
      rst = (rr == 99) && ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
